// File: rtl/itree_channel_scheduler.sv
// Round-robin scheduler sharing one isolation-tree scoring engine across NUM_CH sensor channels.
// Tree reloads pre-empt samples at IDLE. Define ITREE_SCHED_STATS_EN to add the anomaly_count output.
module itree_channel_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int TREE_W  = 256,
    parameter int TIMEOUT = 63
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         ch_valid,
    input  logic [NUM_CH*DATA_W-1:0]  ch_data,
    output logic [NUM_CH-1:0]         ch_ready,
    input  logic                      cfg_load_req,
    input  logic [TREE_W-1:0]         cfg_tree,
    output logic                      cfg_load_ack,
    output logic [DATA_W-1:0]         eng_data_input,
    output logic                      eng_data_valid,
    output logic                      eng_load_itree,
    output logic [TREE_W-1:0]         eng_itree_input,
    input  logic                      eng_done,
    input  logic                      eng_anomaly,
    output logic                      res_valid,
    output logic [$clog2(NUM_CH)-1:0] res_ch,
    output logic                      res_anomaly,
    output logic                      res_timeout
`ifdef ITREE_SCHED_STATS_EN
    ,
    output logic [15:0]               anomaly_count
`endif
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_REPORT
    } state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     last_grant_q, last_grant_d;
    logic [CH_W-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [TREE_W-1:0]   tree_q, tree_d;
    logic [7:0]          timer_q, timer_d;
    logic [CH_W-1:0]     res_ch_q, res_ch_d;
    logic                res_anom_q, res_anom_d;
    logic                res_to_q, res_to_d;
    logic [15:0]         cnt_q, cnt_d;

    logic                found;
    logic [CH_W-1:0]     winner;
    logic [CH_W-1:0]     cand;
    logic [DATA_W-1:0]   win_data;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand     = '0;
        win_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = CH_W'((int'(last_grant_q) + 1 + k) % NUM_CH);
            if (!found && ch_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (CH_W'(k) == winner) win_data = ch_data[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;
        data_d       = data_q;
        tree_d       = tree_q;
        timer_d      = timer_q;
        res_ch_d     = res_ch_q;
        res_anom_d   = res_anom_q;
        res_to_d     = res_to_q;
        cnt_d        = cnt_q;
        ch_ready     = '0;
        case (state_q)
            S_IDLE: begin
                if (cfg_load_req) begin
                    tree_d  = cfg_tree;
                    state_d = S_LOAD;
                end else if (found) begin
                    // ch_ready is gated by reset so every output reads 0 while reset is held.
                    ch_ready[winner] = !reset;
                    data_d       = win_data;
                    idx_d        = winner;
                    last_grant_d = winner;
                    state_d      = S_ISSUE;
                end
            end
            S_LOAD: state_d = S_IDLE;
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 8'd1;
                if (eng_done) begin
                    res_ch_d   = idx_q;
                    res_anom_d = eng_anomaly;
                    res_to_d   = 1'b0;
                    state_d    = S_REPORT;
                end else if (timer_q == 8'(TIMEOUT - 1)) begin
                    res_ch_d   = idx_q;
                    res_anom_d = 1'b0;
                    res_to_d   = 1'b1;
                    state_d    = S_REPORT;
                end
            end
            S_REPORT: begin
                if (res_anom_q && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= CH_W'(NUM_CH - 1);
            idx_q        <= '0;
            data_q       <= '0;
            tree_q       <= '0;
            timer_q      <= '0;
            res_ch_q     <= '0;
            res_anom_q   <= 1'b0;
            res_to_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            tree_q       <= tree_d;
            timer_q      <= timer_d;
            res_ch_q     <= res_ch_d;
            res_anom_q   <= res_anom_d;
            res_to_q     <= res_to_d;
            cnt_q        <= cnt_d;
        end
    end

    assign cfg_load_ack    = (state_q == S_LOAD);
    assign eng_load_itree  = (state_q == S_LOAD);
    assign eng_itree_input = tree_q;
    assign eng_data_valid  = (state_q == S_ISSUE);
    assign eng_data_input  = data_q;
    assign res_valid       = (state_q == S_REPORT);
    assign res_ch          = res_ch_q;
    assign res_anomaly     = res_anom_q;
    assign res_timeout     = res_to_q;

`ifdef ITREE_SCHED_STATS_EN
    assign anomaly_count = cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_q;
`endif

endmodule

// File: tb/tb_itree_channel_scheduler.sv
// Randomized self-checking bench for itree_channel_scheduler: an engine model plus a
// round-robin/latency reference scoreboard, and directed scenario tasks.
module tb_itree_channel_scheduler;
    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 8;
    localparam int TREE_W  = 256;
    localparam int TIMEOUT = 63;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_CH-1:0]         ch_valid;
    logic [NUM_CH*DATA_W-1:0]  ch_data;
    logic [NUM_CH-1:0]         ch_ready;
    logic                      cfg_load_req;
    logic [TREE_W-1:0]         cfg_tree;
    logic                      cfg_load_ack;
    logic [DATA_W-1:0]         eng_data_input;
    logic                      eng_data_valid;
    logic                      eng_load_itree;
    logic [TREE_W-1:0]         eng_itree_input;
    logic                      eng_done = 1'b0;
    logic                      eng_anomaly = 1'b0;
    logic                      res_valid;
    logic [1:0]                res_ch;
    logic                      res_anomaly;
    logic                      res_timeout;
`ifdef ITREE_SCHED_STATS_EN
    logic [15:0]               anomaly_count;
`endif

    itree_channel_scheduler #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TREE_W(TREE_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
        .cfg_load_req(cfg_load_req), .cfg_tree(cfg_tree), .cfg_load_ack(cfg_load_ack),
        .eng_data_input(eng_data_input), .eng_data_valid(eng_data_valid),
        .eng_load_itree(eng_load_itree), .eng_itree_input(eng_itree_input),
        .eng_done(eng_done), .eng_anomaly(eng_anomaly),
        .res_valid(res_valid), .res_ch(res_ch), .res_anomaly(res_anomaly), .res_timeout(res_timeout)
`ifdef ITREE_SCHED_STATS_EN
        , .anomaly_count(anomaly_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Engine and scoreboard controls: lat_sel -1 random, 0 never responds, >0 fixed latency.
    int   lat_sel = -1;
    int   verd_sel = -1;
    bit   spur_en = 1'b0;
    int   cyc = 0;
    int   m_last = NUM_CH - 1;
    bit   infl = 1'b0;
    bit   issued = 1'b0;
    int   q_ch = 0;
    logic [7:0] q_data = '0;
    int   eng_cnt = 0;
    logic eng_verdict = 1'b0;
    int   exp_res_cyc = 0;
    bit   exp_to = 1'b0;
    logic exp_an = 1'b0;
    int   n_acc = 0;
    int   n_res = 0;

    always @(negedge clk) begin
        int exp_g, got, lat, c;
        cyc++;
        if (reset) begin
            infl = 0; issued = 0; m_last = NUM_CH - 1; eng_cnt = 0;
            eng_done = 0; eng_anomaly = 0;
        end else begin
            eng_done = 0;
            eng_anomaly = 1'($urandom);
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin eng_done = 1; eng_anomaly = eng_verdict; end
            end else if (spur_en && !infl && $urandom_range(3) == 0) begin
                eng_done = 1;
            end
            checks++;
            if ((cfg_load_req && ch_ready != 0) || (ch_ready & ~ch_valid) != 0 || !$onehot0(ch_ready)) begin
                errors++;
                $display("FAIL ready_legal: ch_ready=%b ch_valid=%b cfg_load_req=%b", ch_ready, ch_valid, cfg_load_req);
            end
            if ((ch_ready & ch_valid) != 0) begin
                exp_g = -1; got = -1;
                for (int k = 0; k < NUM_CH; k++) begin
                    c = (m_last + 1 + k) % NUM_CH;
                    if (exp_g < 0 && ch_valid[c]) exp_g = c;
                end
                for (int k = 0; k < NUM_CH; k++) if (ch_ready[k]) got = k;
                checks++;
                if (got != exp_g || infl) begin
                    errors++;
                    $display("FAIL grant: got ch %0d expected ch %0d (busy=%0d)", got, exp_g, infl);
                end
                m_last = got; infl = 1; issued = 0; q_ch = got;
                q_data = ch_data[got*DATA_W +: DATA_W];
                n_acc++;
            end
            if (eng_data_valid) begin
                checks++;
                if (!infl || issued || eng_data_input !== q_data) begin
                    errors++;
                    $display("FAIL issue_data: got %h expected %h (busy=%0d issued=%0d)", eng_data_input, q_data, infl, issued);
                end
                issued = 1;
                if (lat_sel < 0) lat = ($urandom_range(15) == 0) ? 0 : 1 + $urandom_range(7);
                else lat = lat_sel;
                eng_verdict = (verd_sel < 0) ? 1'($urandom) : 1'(verd_sel);
                eng_cnt = lat;
                exp_to = (lat == 0 || lat > TIMEOUT);
                exp_an = exp_to ? 1'b0 : eng_verdict;
                exp_res_cyc = cyc + (exp_to ? TIMEOUT : lat) + 1;
            end
            if (res_valid) begin
                checks++;
                if (!issued || res_ch !== 2'(q_ch) || res_anomaly !== exp_an || res_timeout !== exp_to || cyc != exp_res_cyc) begin
                    errors++;
                    $display("FAIL result: ch=%0d an=%b to=%b cyc=%0d expected ch=%0d an=%b to=%b cyc=%0d issued=%0d",
                             res_ch, res_anomaly, res_timeout, cyc, q_ch, exp_an, exp_to, exp_res_cyc, issued);
                end
                infl = 0; issued = 0; n_res++;
            end
            if (cfg_load_ack || eng_load_itree) begin
                checks++;
                if (cfg_load_ack !== 1'b1 || eng_load_itree !== 1'b1 || cfg_load_req !== 1'b1 || eng_itree_input !== cfg_tree) begin
                    errors++;
                    $display("FAIL tree_load: ack=%b load=%b tree=%h expected %h", cfg_load_ack, eng_load_itree, eng_itree_input, cfg_tree);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 reset = 1; ch_valid = '0; cfg_load_req = 0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset = 0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({ch_ready, cfg_load_ack, eng_data_input, eng_data_valid, eng_load_itree, eng_itree_input,
             res_valid, res_ch, res_anomaly, res_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ch_ready=%b eng_data_valid=%b res_valid=%b tree=%h required all zero",
                     ch_ready, eng_data_valid, res_valid, eng_itree_input);
        end
`ifdef ITREE_SCHED_STATS_EN
        checks++;
        if (anomaly_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", anomaly_count); end
`endif
        @(posedge clk); #1 ch_valid = '0; reset = 0;
    endtask

    task automatic test_single();
        bit ok;
        int i;
        lat_sel = 3; verd_sel = 0;
        @(posedge clk); #1 ch_data = {24'($urandom), 8'h00}; ch_valid = 4'b0001;
        ok = 0;
        for (i = 0; i < 50; i++) begin @(negedge clk); if (ch_ready != 0) begin ok = 1; break; end end
        checks++;
        if (!ok || ch_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: ch_ready=%b required 0001", ch_ready); end
        @(posedge clk); #1 ch_valid = '0;
        @(negedge clk);
        checks++;
        if (eng_data_valid !== 1'b1 || eng_data_input !== 8'h00) begin
            errors++; $display("FAIL single_issue: valid=%b data=%h required 1/00", eng_data_valid, eng_data_input);
        end
        ok = 0;
        for (i = 0; i < 100; i++) begin @(negedge clk); if (res_valid) begin ok = 1; break; end end
        checks++;
        if (!ok || i != 3 || res_ch !== 2'd0 || res_anomaly !== 1'b0 || res_timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_result: seen=%0d delay=%0d ch=%0d an=%b to=%b required delay 3 ch 0 an 0 to 0",
                     ok, i, res_ch, res_anomaly, res_timeout);
        end
    endtask

    task automatic test_round_robin();
        int g[5];
        logic [7:0] d[5];
        int exp_g[5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_d[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        int ng, nd;
        do_reset();
        lat_sel = -1; verd_sel = -1;
        ch_data = {8'h44, 8'h33, 8'h22, 8'h11}; ch_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin g[k] = -1; d[k] = 'x; end
        ng = 0; nd = 0;
        for (int i = 0; i < 600 && nd < 5; i++) begin
            @(negedge clk);
            if (eng_data_valid) begin d[nd] = eng_data_input; nd++; end
            if ((ch_ready & ch_valid) != 0 && ng < 5) begin
                for (int k = 0; k < NUM_CH; k++) if (ch_ready[k]) g[ng] = k;
                ng++;
                if (ng == 5) begin @(posedge clk); #1 ch_valid = '0; end
            end
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (g[k] != exp_g[k] || d[k] !== exp_d[k]) begin
                errors++;
                $display("FAIL rr_order[%0d]: grant %0d data %h required grant %0d data %h", k, g[k], d[k], exp_g[k], exp_d[k]);
            end
        end
        drain(80);
    endtask

    task automatic test_cfg_priority();
        bit ok, ld;
        int res_at, ack_at, gnt_at, gch;
        logic [TREE_W-1:0] tr, want;
        want = {192'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        lat_sel = 6; verd_sel = 1;
        @(posedge clk); #1 ch_data[15:8] = 8'h5A; ch_valid = 4'b0010;
        ok = 0;
        for (int i = 0; i < 100; i++) begin @(negedge clk); if (eng_data_valid) begin ok = 1; break; end end
        @(posedge clk); #1 cfg_tree = want; cfg_load_req = 1;
        res_at = -1; ack_at = -1; gnt_at = -1; gch = -1; ld = 0; tr = '0;
        for (int i = 0; i < 100 && gnt_at < 0; i++) begin
            @(negedge clk);
            if (res_valid && res_at < 0) res_at = i;
            if ((ch_ready & ch_valid) != 0) begin
                gnt_at = i;
                for (int k = 0; k < NUM_CH; k++) if (ch_ready[k]) gch = k;
            end
            if (cfg_load_ack) begin
                ack_at = i; ld = eng_load_itree; tr = eng_itree_input;
                @(posedge clk); #1 cfg_load_req = 0;
            end
        end
        checks++;
        if (!ok || res_at < 0 || ack_at <= res_at || gnt_at <= ack_at) begin
            errors++;
            $display("FAIL cfg_order: issue=%0d res@%0d ack@%0d grant@%0d required res<ack<grant", ok, res_at, ack_at, gnt_at);
        end
        checks++;
        if (ld !== 1'b1 || tr !== want) begin
            errors++; $display("FAIL cfg_tree: load=%b tree=%h required 1 and %h", ld, tr, want);
        end
        checks++;
        if (gch != 1) begin errors++; $display("FAIL cfg_next_grant: got ch %0d required 1", gch); end
        @(posedge clk); #1 ch_valid = '0;
        drain(20);
    endtask

    task automatic test_timeout();
        int lats[3] = '{0, TIMEOUT, TIMEOUT + 1};
        bit tos[3]  = '{1, 0, 1};
        bit ans[3]  = '{0, 1, 0};
        bit ok;
        int i;
        verd_sel = 1;
        for (int t = 0; t < 3; t++) begin
            lat_sel = lats[t];
            @(posedge clk); #1 ch_data[23:16] = 8'($urandom); ch_valid = 4'b0100;
            ok = 0;
            for (i = 0; i < 50; i++) begin @(negedge clk); if (eng_data_valid) begin ok = 1; break; end end
            @(posedge clk); #1 ch_valid = '0;
            i = 1;
            while (i < 200) begin @(negedge clk); if (res_valid) break; i++; end
            checks++;
            if (!ok || i != TIMEOUT + 1 || res_timeout !== tos[t] || res_anomaly !== ans[t]) begin
                errors++;
                $display("FAIL timeout[lat=%0d]: issue=%0d delay=%0d to=%b an=%b required delay %0d to=%b an=%b",
                         lats[t], ok, i, res_timeout, res_anomaly, TIMEOUT + 1, tos[t], ans[t]);
            end
            drain(5);
        end
        lat_sel = -1; verd_sel = -1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int nr;
        lat_sel = 0;
        @(posedge clk); #1 ch_valid = 4'b1000;
        ok = 0;
        for (int i = 0; i < 50; i++) begin @(negedge clk); if (eng_data_valid) begin ok = 1; break; end end
        @(posedge clk); #1 ch_valid = '0;
        repeat (5) @(negedge clk);
        @(posedge clk); #2 reset = 1; ch_valid = 4'hF;
        #1;
        checks++;
        if (!ok || {ch_ready, cfg_load_ack, eng_data_input, eng_data_valid, eng_load_itree, eng_itree_input,
                    res_valid, res_ch, res_anomaly, res_timeout} !== '0) begin
            errors++;
            $display("FAIL async_reset: issue=%0d ch_ready=%b data=%h tree=%h res_ch=%0d required all zero",
                     ok, ch_ready, eng_data_input, eng_itree_input, res_ch);
        end
        #1 ch_valid = '0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset = 0; lat_sel = -1;
        nr = 0;
        repeat (80) begin @(negedge clk); if (res_valid) nr++; end
        checks++;
        if (nr != 0) begin errors++; $display("FAIL abort_result: got %0d results required 0", nr); end
        @(posedge clk); #1 ch_valid = 4'hF;
        ok = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (ch_ready != 0) begin ok = 1; break; end end
        checks++;
        if (!ok || ch_ready !== 4'b0001) begin errors++; $display("FAIL post_reset_grant: ch_ready=%b required 0001", ch_ready); end
        @(posedge clk); #1 ch_valid = '0;
        drain(80);
    endtask

    task automatic test_random();
        int acc0, res0, da, dr;
        bit a;
        acc0 = n_acc; res0 = n_res;
        lat_sel = -1; verd_sel = -1; spur_en = 1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); a = cfg_load_ack;
            @(posedge clk); #1;
            ch_valid = 4'($urandom);
            ch_data  = 32'($urandom);
            if (a) cfg_load_req = 0;
            else if (!cfg_load_req && $urandom_range(30) == 0) begin
                for (int k = 0; k < TREE_W / 32; k++) cfg_tree[k*32 +: 32] = $urandom;
                cfg_load_req = 1;
            end
        end
        ch_valid = '0;
        for (int i = 0; i < 120 && cfg_load_req; i++) begin
            @(negedge clk); a = cfg_load_ack;
            if (a) begin @(posedge clk); #1 cfg_load_req = 0; end
        end
        drain(100);
        spur_en = 0;
        da = n_acc - acc0; dr = n_res - res0;
        checks++;
        if (da == 0 || da != dr || cfg_load_req) begin
            errors++; $display("FAIL random_balance: accepted %0d results %0d req_pending=%0d required equal and nonzero", da, dr, cfg_load_req);
        end
    endtask

`ifdef ITREE_SCHED_STATS_EN
    task automatic test_stats();
        bit ok;
        do_reset();
        lat_sel = 2;
        for (int k = 0; k < 4; k++) begin
            verd_sel = (k < 3) ? 1 : 0;
            ch_valid = 4'(1 << k);
            ok = 0;
            for (int i = 0; i < 50; i++) begin @(negedge clk); if (ch_ready != 0) begin ok = 1; break; end end
            @(posedge clk); #1 ch_valid = '0;
            drain(10);
            @(posedge clk); #1;
        end
        checks++;
        if (anomaly_count !== 16'd3) begin errors++; $display("FAIL anomaly_count: got %0d required 3", anomaly_count); end
        lat_sel = -1; verd_sel = -1;
    endtask
`endif

    initial begin
        reset = 1; ch_valid = '1; ch_data = '0; cfg_load_req = 0; cfg_tree = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_cfg_priority();
        test_timeout();
        test_reset_mid();
        test_random();
`ifdef ITREE_SCHED_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
